// File: rtl/alu_md_pkg.sv
// Shared encodings for the ALU/multiply-divide unit: FSM states, M-extension
// op codes and base-result source selects.
package alu_md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } m_op_e;

    localparam logic [1:0] SRC_ADDER = 2'd0;
    localparam logic [1:0] SRC_LOGIC = 2'd1;
    localparam logic [1:0] SRC_SHIFT = 2'd2;
    localparam logic [1:0] SRC_CMP   = 2'd3;

    function automatic logic is_div(input m_op_e op);
        return op[2];
    endfunction

    function automatic logic is_signed_div(input m_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu.sv
// Base combinational ALU: adder, logic, shifter and compare units selected by
// alu_mux2_select; alu_mux1_select picks the opd1/opd2 or opd3/opd4 pair.
module alu
    import alu_md_pkg::*;
#(
    parameter int OPERAND_LENGTH = 32
) (
    input  logic [OPERAND_LENGTH-1:0] opd1,
    input  logic [OPERAND_LENGTH-1:0] opd2,
    input  logic [OPERAND_LENGTH-1:0] opd3,
    input  logic [OPERAND_LENGTH-1:0] opd4,
    input  logic [3:0]                alu_op_select,
    input  logic                      alu_mux1_select,
    input  logic [1:0]                alu_mux2_select,
    output logic [OPERAND_LENGTH-1:0] result
);
    localparam int N  = OPERAND_LENGTH;
    localparam int SW = $clog2(N);

    logic [N-1:0] a, b, add_res, logic_res, shift_res, cmp_res;
    logic [SW-1:0] sh;

    assign a  = alu_mux1_select ? opd3 : opd1;
    assign b  = alu_mux1_select ? opd4 : opd2;
    assign sh = b[SW-1:0];

    always_comb begin
        add_res = (alu_op_select == 4'd1) ? a - b : a + b;

        case (alu_op_select)
            4'd0:    logic_res = a & b;
            4'd1:    logic_res = a | b;
            4'd2:    logic_res = a ^ b;
            default: logic_res = ~(a | b);
        endcase

        case (alu_op_select)
            4'd0:    shift_res = a << sh;
            4'd1:    shift_res = a >> sh;
            4'd2:    shift_res = $unsigned($signed(a) >>> sh);
            default: shift_res = a;
        endcase

        case (alu_op_select)
            4'd0:    cmp_res = N'($signed(a) < $signed(b));
            4'd1:    cmp_res = N'(a < b);
            4'd2:    cmp_res = N'(a == b);
            default: cmp_res = '0;
        endcase

        case (alu_mux2_select)
            SRC_ADDER: result = add_res;
            SRC_LOGIC: result = logic_res;
            SRC_SHIFT: result = shift_res;
            default:   result = cmp_res;
        endcase
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add, K bits per step) and restoring divide on
// operand magnitudes; res is the sign-corrected value of the final step.
module muldiv_iter
    import alu_md_pkg::*;
#(
    parameter int OPERAND_LENGTH     = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      step,
    input  m_op_e                     op,
    input  logic [OPERAND_LENGTH-1:0] opd1,
    input  logic [OPERAND_LENGTH-1:0] opd2,
    output logic                      last,
    output logic [OPERAND_LENGTH-1:0] res
);
    localparam int N  = OPERAND_LENGTH;
    localparam int K  = MUL_BITS_PER_CYCLE;
    localparam int W2 = 2 * N;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(N / K - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(N - 1);

    m_op_e         op_q;
    logic          neg_q, rneg_q;
    logic [CW-1:0] cnt;
    logic [W2-1:0] prod_q, mcand_q, prod_nxt, prod_signed;
    logic [N-1:0]  mplier_q, quo_q, rem_q, dvs_q, quo_nxt, rem_nxt;
    logic [N:0]    trial, diff;
    logic          neg1, neg2;
    logic [N-1:0]  mag1, mag2;

    assign neg1 = (op == OP_MULH || op == OP_MULHSU || is_signed_div(op)) && opd1[N-1];
    assign neg2 = (op == OP_MULH || is_signed_div(op)) && opd2[N-1];
    assign mag1 = neg1 ? -opd1 : opd1;
    assign mag2 = neg2 ? -opd2 : opd2;

    assign prod_nxt = prod_q + mcand_q * W2'(mplier_q[K-1:0]);
    assign trial    = {rem_q, quo_q[N-1]};
    assign diff     = trial - {1'b0, dvs_q};
    assign rem_nxt  = diff[N] ? trial[N-1:0] : diff[N-1:0];
    assign quo_nxt  = {quo_q[N-2:0], ~diff[N]};

    assign last        = step && (cnt == (is_div(op_q) ? DIV_LAST : MUL_LAST));
    assign prod_signed = neg_q ? -prod_nxt : prod_nxt;

    always_comb begin
        case (op_q)
            OP_MUL:              res = prod_nxt[N-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:            res = prod_signed[W2-1:N];
            OP_DIV, OP_DIVU:     res = neg_q ? -quo_nxt : quo_nxt;
            default:             res = rneg_q ? -rem_nxt : rem_nxt;
        endcase
    end

    // NOTE: the datapath registers are reset too, so an abort by rst_n leaves
    // no stale operand state behind; state uses non-blocking assignment only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt      <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
        end else if (start) begin
            op_q     <= op;
            neg_q    <= neg1 ^ neg2;
            rneg_q   <= neg1;
            cnt      <= '0;
            prod_q   <= '0;
            mcand_q  <= W2'(mag1);
            mplier_q <= mag2;
            quo_q    <= mag1;
            rem_q    <= '0;
            dvs_q    <= mag2;
        end else if (step) begin
            cnt      <= cnt + 1'b1;
            prod_q   <= prod_nxt;
            mcand_q  <= mcand_q << K;
            mplier_q <= mplier_q >> K;
            quo_q    <= quo_nxt;
            rem_q    <= rem_nxt;
        end
    end

endmodule

// File: rtl/alu_md.sv
// ALU with M-extension: base ops complete in one cycle, multiply/divide run
// iteratively; results leave through a valid/ready handshake.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int OPERAND_LENGTH     = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPERAND_LENGTH-1:0] opd1,
    input  logic [OPERAND_LENGTH-1:0] opd2,
    input  logic [3:0]                alu_op_select,
    input  logic [1:0]                alu_mux2_select,
    input  logic                      m_ext,
    input  logic [2:0]                m_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPERAND_LENGTH-1:0] result
);
    localparam int N = OPERAND_LENGTH;
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    state_e       state, state_nxt, req_state;
    m_op_e        op_in;
    logic         accept, iter_last;
    logic [N-1:0] alu_res, iter_res, req_result, result_nxt;

    assign op_in     = m_op_e'(m_op);
    assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    alu #(.OPERAND_LENGTH(N)) u_alu (
        .opd1            (opd1),
        .opd2            (opd2),
        .opd3            (opd1),
        .opd4            (opd2),
        .alu_op_select   (alu_op_select),
        .alu_mux1_select (1'b0),
        .alu_mux2_select (alu_mux2_select),
        .result          (alu_res)
    );

    muldiv_iter #(
        .OPERAND_LENGTH     (N),
        .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && m_ext),
        .step  (state == ST_MUL || state == ST_DIV),
        .op    (op_in),
        .opd1  (opd1),
        .opd2  (opd2),
        .last  (iter_last),
        .res   (iter_res)
    );

    // Where a newly accepted request goes; divide-by-zero and signed overflow
    // resolve immediately instead of iterating.
    always_comb begin
        req_state  = ST_DONE;
        req_result = alu_res;
        if (m_ext) begin
            if (is_div(op_in) && opd2 == '0)
                req_result = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : opd1;
            else if (is_signed_div(op_in) && opd1 == MOST_NEG && opd2 == '1)
                req_result = (op_in == OP_DIV) ? MOST_NEG : '0;
            else
                req_state = is_div(op_in) ? ST_DIV : ST_MUL;
        end
    end

    // NOTE: defaults first so every path assigns state_nxt/result_nxt and no
    // latch is inferred.
    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        if (accept) begin
            state_nxt = req_state;
            if (req_state == ST_DONE)
                result_nxt = req_result;
        end else begin
            case (state)
                ST_MUL, ST_DIV: begin
                    if (iter_last) begin
                        state_nxt  = ST_DONE;
                        result_nxt = iter_res;
                    end
                end
                ST_DONE: if (out_ready) state_nxt = ST_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            result <= '0;
        end else begin
            state  <= state_nxt;
            result <= result_nxt;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md (32-bit, 1 multiplier bit/cycle).
module tb_alu_md;
    import alu_md_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] opd1 = '0;
    logic [31:0] opd2 = '0;
    logic [3:0]  alu_op_select = '0;
    logic [1:0]  alu_mux2_select = '0;
    logic        m_ext = 1'b0;
    logic [2:0]  m_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_md #(.OPERAND_LENGTH(32), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .opd1            (opd1),
        .opd2            (opd2),
        .alu_op_select   (alu_op_select),
        .alu_mux2_select (alu_mux2_select),
        .m_ext           (m_ext),
        .m_op            (m_op),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .result          (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] aop,
                         input logic [1:0] src, input logic mx, input logic [2:0] mop);
        opd1 = a; opd2 = b; alu_op_select = aop; alu_mux2_select = src;
        m_ext = mx; m_op = mop; in_valid = 1'b1;
    endtask

    // Issue one request and wait for its result; latency counts the accept edge as 1.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] aop, input logic [1:0] src, input logic mx,
                          input logic [2:0] mop, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int rdy_busy;
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        drive(a, b, aop, src, mx, mop);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        rdy_busy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_busy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " result"}, result, exp_res);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " ready_busy"}, 32'(rdy_busy), 32'd0);
    endtask

    initial begin
        #2;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset result", result, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Base ops
        run_op("add",  32'd5, 32'd7, 4'd0, SRC_ADDER, 1'b0, 3'd0, 32'd12, 1);
        run_op("sub",  32'd10, 32'd3, 4'd1, SRC_ADDER, 1'b0, 3'd0, 32'd7, 1);
        run_op("and",  32'h0000_F0F0, 32'h0000_FF00, 4'd0, SRC_LOGIC, 1'b0, 3'd0, 32'h0000_F000, 1);
        run_op("sll",  32'd1, 32'd4, 4'd0, SRC_SHIFT, 1'b0, 3'd0, 32'd16, 1);
        run_op("sra",  32'h8000_0000, 32'd4, 4'd2, SRC_SHIFT, 1'b0, 3'd0, 32'hF800_0000, 1);
        run_op("slt",  32'hFFFF_FFFF, 32'd0, 4'd0, SRC_CMP, 1'b0, 3'd0, 32'd1, 1);

        // Back-to-back adds: one result per cycle
        drive(32'd1, 32'd2, 4'd0, SRC_ADDER, 1'b0, 3'd0);
        @(posedge clk); #1;
        check("b2b0 result", result, 32'd3);
        check("b2b0 valid", 32'(out_valid), 32'd1);
        drive(32'd100, 32'd200, 4'd0, SRC_ADDER, 1'b0, 3'd0);
        @(posedge clk); #1;
        check("b2b1 result", result, 32'd300);
        check("b2b1 valid", 32'(out_valid), 32'd1);
        drive(32'hFFFF_FFFF, 32'd1, 4'd0, SRC_ADDER, 1'b0, 3'd0);
        @(posedge clk); #1;
        check("b2b2 result", result, 32'd0);
        check("b2b2 valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;

        // Multiplies
        run_op("mulhu",   32'hFFFF_FFFF, 32'd2, 4'd0, 2'd0, 1'b1, OP_MULHU, 32'h0000_0001, 33);
        run_op("mulh",    32'hFFFF_FFFF, 32'd2, 4'd0, 2'd0, 1'b1, OP_MULH, 32'hFFFF_FFFF, 33);
        run_op("mul",     32'hFFFF_FFFF, 32'd2, 4'd0, 2'd0, 1'b1, OP_MUL, 32'hFFFF_FFFE, 33);
        run_op("mul2",    32'd12345, 32'd678, 4'd0, 2'd0, 1'b1, OP_MUL, 32'd8369910, 33);
        run_op("mulhsu",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 2'd0, 1'b1, OP_MULHSU, 32'hFFFF_FFFF, 33);
        run_op("mulhu2",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 2'd0, 1'b1, OP_MULHU, 32'hFFFF_FFFE, 33);
        run_op("mulh2",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 2'd0, 1'b1, OP_MULH, 32'h0000_0000, 33);

        // Divides
        run_op("div",   32'hFFFF_FFF9, 32'd2, 4'd0, 2'd0, 1'b1, OP_DIV, 32'hFFFF_FFFD, 33);
        run_op("rem",   32'hFFFF_FFF9, 32'd2, 4'd0, 2'd0, 1'b1, OP_REM, 32'hFFFF_FFFF, 33);
        run_op("divu",  32'd100, 32'd7, 4'd0, 2'd0, 1'b1, OP_DIVU, 32'd14, 33);
        run_op("remu",  32'd100, 32'd7, 4'd0, 2'd0, 1'b1, OP_REMU, 32'd2, 33);
        run_op("div_nd", 32'd7, 32'hFFFF_FFFE, 4'd0, 2'd0, 1'b1, OP_DIV, 32'hFFFF_FFFD, 33);
        run_op("rem_nd", 32'd7, 32'hFFFF_FFFE, 4'd0, 2'd0, 1'b1, OP_REM, 32'd1, 33);

        // Divide-by-zero and signed overflow resolve in one cycle
        run_op("divu_z", 32'h0000_1234, 32'd0, 4'd0, 2'd0, 1'b1, OP_DIVU, 32'hFFFF_FFFF, 1);
        run_op("remu_z", 32'h0000_1234, 32'd0, 4'd0, 2'd0, 1'b1, OP_REMU, 32'h0000_1234, 1);
        run_op("div_z",  32'd5, 32'd0, 4'd0, 2'd0, 1'b1, OP_DIV, 32'hFFFF_FFFF, 1);
        run_op("div_ov", 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 2'd0, 1'b1, OP_DIV, 32'h8000_0000, 1);
        run_op("rem_ov", 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 2'd0, 1'b1, OP_REM, 32'h0000_0000, 1);

        // Back-pressure: result held while out_ready is low, no accept meanwhile
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_op("bp_mul", 32'd3, 32'd5, 4'd0, 2'd0, 1'b1, OP_MUL, 32'd15, 33);
        drive(32'd2, 32'd2, 4'd0, SRC_ADDER, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp ready low", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            check("bp valid held", 32'(out_valid), 32'd1);
            check("bp result held", result, 32'd15);
        end
        out_ready = 1'b1;
        #1;
        check("bp release ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp next result", result, 32'd4);
        check("bp next valid", 32'(out_valid), 32'd1);

        // Reset in the middle of a divide
        drive(32'd1000, 32'd3, 4'd0, 2'd0, 1'b1, OP_DIVU);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("mid div busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst result", result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op("post_rst add", 32'd1, 32'd1, 4'd0, SRC_ADDER, 1'b0, 3'd0, 32'd2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL provide parameter OPERAND_LENGTH, default 32, datapath width in bits; even and at least 8.
REQ-002 SHALL provide parameter MUL_BITS_PER_CYCLE, default 1, multiplier bits retired per cycle; one of 1, 2, 4, and divides OPERAND_LENGTH.
REQ-003 SHALL provide ports, in order:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: request present.
- in_ready, output, 1: request accepted when in_valid && in_ready.
- opd1, input, OPERAND_LENGTH: operand 1 / dividend / multiplicand.
- opd2, input, OPERAND_LENGTH: operand 2 / divisor / multiplier.
- alu_op_select, input, 4: base-op code, existing encoding.
- alu_mux2_select, input, 2: base result source (0 adder, 1 logic, 2 shifter, 3 compare).
- m_ext, input, 1: 1 selects an M-extension op; 0 selects a base op.
- m_op, input, 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- out_valid, output, 1: result present.
- out_ready, input, 1: result consumed when out_valid && out_ready.
- result, output, OPERAND_LENGTH: registered result.

Function
REQ-004 SHALL capture opd1, opd2, alu_op_select, alu_mux2_select, m_ext and m_op only on accept.
REQ-005 SHALL implement states IDLE, MUL, DIV and DONE.
REQ-006 SHALL hold in_ready=1 in IDLE and in DONE with out_ready=1, and 0 otherwise; an accept in DONE SHALL overlap the output handshake.
REQ-007 SHALL complete a base op (m_ext=0) in 1 cycle: IDLE->DONE, out_valid=1 in the cycle after accept.
REQ-008 SHALL complete a multiply in OPERAND_LENGTH/MUL_BITS_PER_CYCLE cycles in MUL, followed by DONE.
- Algorithm: shift-add over a 2*OPERAND_LENGTH product.
- Sign handling: MULH signed x signed; MULHSU signed x unsigned.
- Result: MUL returns the low half of the product; MULH, MULHSU and MULHU return the high half.
REQ-009 SHALL complete a divide in OPERAND_LENGTH cycles in DIV, followed by DONE.
- Algorithm: restoring division on magnitudes; signs fixed up in the final cycle.
- Quotient sign: truncates toward zero.
- Remainder sign: follows the dividend.
REQ-010 SHALL, for divisor 0, skip DIV and enter DONE in 1 cycle.
- DIV and DIVU return all-ones.
- REM and REMU return opd1.
REQ-011 SHALL, for signed DIV/REM of the most negative value by -1, enter DONE in 1 cycle: DIV returns the most negative value, REM returns 0.
REQ-012 SHALL, in DONE with out_ready=0, hold result and out_valid stable; DONE->IDLE on handshake without a new accept.
REQ-013 SHALL ignore in_valid while in MUL or DIV; no abort path.
REQ-014 SHALL keep result stable except on the DONE-entry edge.

Reset
REQ-015 SHALL, on rst_n=0 at any time including mid-MUL or mid-DIV, asynchronously set:
- state=IDLE;
- out_valid=0;
- result=0;
- in_ready=1;
- iteration counter=0;
- all internal operand/accumulator registers=0.
REQ-016 SHALL accept a request in the first rising edge after rst_n deasserts.

Structure
REQ-017 SHALL place the state encoding, m_op code constants and alu_mux2_select constants in shared package alu_md_pkg.
REQ-018 SHALL compute base ops by instantiating the existing ALU, with opd3/opd4 tied to opd1/opd2 and alu_mux1_select=0.
REQ-019 SHALL place the iterative multiply/divide datapath and counter in one sub-module, muldiv_iter.

Verification (OPERAND_LENGTH=32, MUL_BITS_PER_CYCLE=1)
REQ-020 ADD 5+7 with out_ready=1 -> result=12, out_valid=1 one cycle after accept; back-to-back ADDs give one result per cycle.
REQ-021 MULHU and MULH of 0xFFFFFFFF by 2 -> MULHU returns 0x00000001 and MULH returns 0xFFFFFFFF, each 33 cycles after accept; in_ready=0 throughout.
REQ-022 DIV and REM of 0xFFFFFFF9 (-7) by 2 -> DIV returns 0xFFFFFFFD and REM returns 0xFFFFFFFF, each 33 cycles after accept.
REQ-023 DIVU and REMU of 0x1234 by 0, and DIV and REM of 0x80000000 by 0xFFFFFFFF -> 0xFFFFFFFF, 0x1234, 0x80000000 and 0x00000000 respectively, each 1 cycle after accept.
REQ-024 rst_n low at cycle 10 of a DIV -> out_valid=0 and in_ready=1 immediately; next ADD 1+1 returns 2.
REQ-025 out_ready=0 for 3 cycles after a MUL result -> result and out_valid held unchanged; new request accepted on the release cycle.
